// File: rtl/decode_ctrl_pipe.sv
// RV32IM decode/control stage: combinational decode feeding a one-entry output
// register with valid/ready handshake, flush, and a MUL/DIV structural-hazard stall.
module decode_ctrl_pipe #(
  parameter int BITS    = 32,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       ALUCtrl,
  output logic             Branch,
  output logic             MemtoReg,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic             ALUPCSrc,
  output logic             RegWrite,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic             illegal,
  output logic             md_busy,
  output logic [CNT_W-1:0] issue_cnt
);

  // Instruction decode is RV32 only; datapaths narrower than 32 bits are not supported.
  if (BITS < 32) begin : g_bits_unsupported
  end

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int MD_W    = $clog2(MAX_LAT + 1);
  localparam logic [MD_W-1:0] MD_MUL = MD_W'(MUL_LAT - 1);
  localparam logic [MD_W-1:0] MD_DIV = MD_W'(DIV_LAT - 1);

  typedef enum logic [4:0] {
    ALU_NOP = 5'd0, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
    ALU_JAL, ALU_JALR, ALU_AUIPC
  } alu_op_e;

  typedef enum logic [6:0] {
    OP_R      = 7'h33,
    OP_I      = 7'h13,
    OP_LOAD   = 7'h03,
    OP_STORE  = 7'h23,
    OP_BRANCH = 7'h63,
    OP_JAL    = 7'h6F,
    OP_JALR   = 7'h67,
    OP_AUIPC  = 7'h17
  } opcode_e;

  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e md_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_MUL;
      3'd1:    return ALU_MULH;
      3'd2:    return ALU_MULHSU;
      3'd3:    return ALU_MULHU;
      3'd4:    return ALU_DIV;
      3'd5:    return ALU_DIVU;
      3'd6:    return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

  function automatic alu_op_e br_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_BEQ;
      3'd1:    return ALU_BNE;
      3'd4:    return ALU_BLT;
      3'd5:    return ALU_BGE;
      3'd6:    return ALU_BLTU;
      default: return ALU_BGEU;
    endcase
  endfunction

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  alu_op_e d_alu;
  logic    d_ok, d_md;
  logic    is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_auipc;

  always_comb begin
    d_alu    = ALU_NOP;
    d_ok     = 1'b0;
    d_md     = 1'b0;
    is_r     = 1'b0;
    is_i     = 1'b0;
    is_ld    = 1'b0;
    is_st    = 1'b0;
    is_br    = 1'b0;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    is_auipc = 1'b0;
    case (op)
      OP_R: begin
        is_r = 1'b1;
        case (f7)
          7'h00: begin d_ok = 1'b1; d_alu = base_op(f3); end
          7'h20: begin
            if (f3 == 3'd0)      begin d_ok = 1'b1; d_alu = ALU_SUB; end
            else if (f3 == 3'd5) begin d_ok = 1'b1; d_alu = ALU_SRA; end
          end
          7'h01: begin d_ok = 1'b1; d_md = 1'b1; d_alu = md_op(f3); end
          default: ;
        endcase
      end
      OP_I: begin
        is_i = 1'b1;
        // funct7 is immediate bits except for shifts, where it qualifies the op
        if (f3 == 3'd1) begin
          d_ok  = (f7 == 7'h00);
          d_alu = ALU_SLL;
        end else if (f3 == 3'd5) begin
          if (f7 == 7'h00)      begin d_ok = 1'b1; d_alu = ALU_SRL; end
          else if (f7 == 7'h20) begin d_ok = 1'b1; d_alu = ALU_SRA; end
        end else begin
          d_ok  = 1'b1;
          d_alu = base_op(f3);
        end
      end
      OP_LOAD: begin
        is_ld = 1'b1;
        d_ok  = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        d_alu = ALU_ADD;
      end
      OP_STORE: begin
        is_st = 1'b1;
        d_ok  = f3 inside {3'd0, 3'd1, 3'd2};
        d_alu = ALU_ADD;
      end
      OP_BRANCH: begin
        is_br = 1'b1;
        d_ok  = !(f3 inside {3'd2, 3'd3});
        d_alu = br_op(f3);
      end
      OP_JAL:   begin is_jal = 1'b1;   d_ok = 1'b1;          d_alu = ALU_JAL;   end
      OP_JALR:  begin is_jalr = 1'b1;  d_ok = (f3 == 3'd0);  d_alu = ALU_JALR;  end
      OP_AUIPC: begin is_auipc = 1'b1; d_ok = 1'b1;          d_alu = ALU_AUIPC; end
      default: ;
    endcase
  end

  alu_op_e          alu_q;
  logic             md_q;
  logic [MD_W-1:0]  md_cnt;
  logic             accept, fire;

  assign in_ready = rst_n & ~flush & (md_cnt == '0) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign fire     = out_valid & out_ready;
  assign ALUCtrl  = alu_q;
  assign md_busy  = (md_cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_q     <= ALU_NOP;
      Branch    <= 1'b0;
      MemtoReg  <= 1'b0;
      MemWrite  <= 1'b0;
      ALUSrc    <= 1'b0;
      ALUPCSrc  <= 1'b0;
      RegWrite  <= 1'b0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      funct3    <= '0;
      illegal   <= 1'b0;
      md_q      <= 1'b0;
      md_cnt    <= '0;
      issue_cnt <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        alu_q     <= d_ok ? d_alu : ALU_NOP;
        Branch    <= d_ok & (is_jal | is_jalr | is_br);
        MemtoReg  <= d_ok & is_ld;
        MemWrite  <= d_ok & is_st;
        ALUSrc    <= d_ok & (is_i | is_ld | is_st | is_auipc | is_jal | is_jalr);
        ALUPCSrc  <= d_ok & (is_auipc | is_jal | is_jalr);
        RegWrite  <= d_ok & (is_r | is_i | is_ld | is_auipc | is_jal | is_jalr);
        rd        <= instr[11:7];
        rs1       <= instr[19:15];
        rs2       <= instr[24:20];
        funct3    <= f3;
        illegal   <= ~d_ok;
        md_q      <= d_md;
      end else if (flush || fire) begin
        out_valid <= 1'b0;
      end

      if (fire) issue_cnt <= issue_cnt + CNT_W'(1);

      // The stall starts when EX takes the M op, not when decode accepts it
      if (fire && md_q)       md_cnt <= (funct3 < 3'd4) ? MD_MUL : MD_DIV;
      else if (md_cnt != '0)  md_cnt <= md_cnt - MD_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Self-checking bench for decode_ctrl_pipe: directed scenarios plus randomized
// traffic compared cycle by cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_decode_ctrl_pipe;

  localparam int CW   = 4;
  localparam int MLAT = 3;
  localparam int DLAT = 16;

  localparam int A_NOP = 0,  A_ADD = 1,  A_SUB = 2,  A_SLL = 3,  A_SLT = 4,  A_SLTU = 5;
  localparam int A_XOR = 6,  A_SRL = 7,  A_SRA = 8,  A_OR = 9,   A_AND = 10, A_MUL = 11;
  localparam int A_BEQ = 19, A_BNE = 20, A_BLT = 21, A_BGE = 22, A_BLTU = 23, A_BGEU = 24;
  localparam int A_JAL = 25, A_JALR = 26, A_AUIPC = 27;

  localparam logic [31:0] I_ADD  = 32'h003100B3;  // add  x1,x2,x3
  localparam logic [31:0] I_SUB  = 32'h403100B3;  // sub  x1,x2,x3
  localparam logic [31:0] I_ADDI = 32'h00708293;  // addi x5,x1,7
  localparam logic [31:0] I_MUL  = 32'h02628233;  // mul  x4,x5,x6
  localparam logic [31:0] I_DIV  = 32'h0262C3B3;  // div  x7,x5,x6
  localparam logic [31:0] I_LW   = 32'h00412403;  // lw   x8,4(x2)
  localparam logic [31:0] I_BEQ  = 32'h00208463;  // beq  x1,x2,8
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_BADR = 32'h400070B3;  // R-type funct7=0100000 funct3=111

  typedef struct {
    logic [4:0] alu;
    logic [5:0] ctrl;  // {Branch,MemtoReg,MemWrite,ALUSrc,ALUPCSrc,RegWrite}
    logic       ill;
    int         lat;   // EX occupancy of an M op, 0 otherwise
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
  } bundle_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0]   instr = '0;
  logic          in_ready, out_valid, Branch, MemtoReg, MemWrite, ALUSrc, ALUPCSrc, RegWrite;
  logic          illegal, md_busy;
  logic [4:0]    ALUCtrl, rd, rs1, rs2;
  logic [2:0]    funct3;
  logic [CW-1:0] issue_cnt;

  decode_ctrl_pipe #(.BITS(32), .MUL_LAT(MLAT), .DIV_LAT(DLAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .ALUCtrl(ALUCtrl),
    .Branch(Branch), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .ALUPCSrc(ALUPCSrc), .RegWrite(RegWrite), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .illegal(illegal), .md_busy(md_busy), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  int      nchk = 0, nfail = 0;
  int      cyc = 0;          // rising edges seen so far
  int      stall_until = 0;  // first cycle index in which a new accept is allowed
  int      m_cnt = 0;
  bit      m_valid = 1'b0;
  bundle_t m_b;
  logic    last_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    nchk++;
    assert (obs === want) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
    end
  endtask

  function automatic bundle_t ref_decode(input logic [31:0] w);
    bundle_t b;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    bit ok, r, ic, ld, st, br, jal, jalr, aui;
    int alu;
    int base[8];
    int brt[8];
    base = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    brt  = '{A_BEQ, A_BNE, -1, -1, A_BLT, A_BGE, A_BLTU, A_BGEU};
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    {ok, r, ic, ld, st, br, jal, jalr, aui} = '0;
    alu = A_NOP;
    b.lat = 0;
    case (opc)
      7'h33: begin
        r = 1;
        if (f7 == 7'h00) begin ok = 1; alu = base[f3]; end
        else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; alu = A_SUB; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; alu = A_SRA; end
        else if (f7 == 7'h01) begin ok = 1; alu = A_MUL + int'(f3); b.lat = (f3 < 4) ? MLAT : DLAT; end
      end
      7'h13: begin
        ic = 1;
        if (f3 == 3'd1) begin ok = (f7 == 7'h00); alu = A_SLL; end
        else if (f3 == 3'd5) begin
          if (f7 == 7'h00) begin ok = 1; alu = A_SRL; end
          else if (f7 == 7'h20) begin ok = 1; alu = A_SRA; end
        end else begin ok = 1; alu = base[f3]; end
      end
      7'h03: begin ld = 1; ok = (f3 != 3'd3 && f3 < 3'd6); alu = A_ADD; end
      7'h23: begin st = 1; ok = (f3 < 3'd3); alu = A_ADD; end
      7'h63: begin br = 1; ok = (brt[f3] >= 0); alu = brt[f3]; end
      7'h6F: begin jal = 1; ok = 1; alu = A_JAL; end
      7'h67: begin jalr = 1; ok = (f3 == 3'd0); alu = A_JALR; end
      7'h17: begin aui = 1; ok = 1; alu = A_AUIPC; end
      default: ;
    endcase
    b.ctrl = {jal | jalr | br, ld, st, ic | ld | st | aui | jal | jalr,
              aui | jal | jalr, r | ic | ld | aui | jal | jalr};
    b.alu = 5'(alu);
    b.ill = !ok;
    if (!ok) begin b.alu = 5'(A_NOP); b.ctrl = '0; b.lat = 0; end
    b.rd = w[11:7]; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.f3 = f3;
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops[8];
    int s, f;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h17};
    w = $urandom;
    s = $urandom_range(0, 9);
    if (s < 8) w[6:0] = ops[s];
    else if (s == 8) w[6:0] = 7'h37;
    f = $urandom_range(0, 4);
    if (f <= 1) w[31:25] = 7'h00;
    else if (f == 2) w[31:25] = 7'h20;
    else if (f == 3) w[31:25] = 7'h01;
    return w;
  endfunction

  // One clock cycle: check in_ready against the model, advance across the edge, check outputs.
  task automatic step();
    logic r, iv, f, ordy, rdy, fire;
    logic [31:0] w;
    #2;
    rdy = rst_n && !flush && (cyc >= stall_until) && (!m_valid || out_ready);
    chk("in_ready", in_ready, rdy);
    last_rdy = in_ready;
    r = rst_n; iv = in_valid; f = flush; ordy = out_ready; w = instr;
    @(posedge clk);
    if (!r) begin
      m_valid = 0; m_cnt = 0; stall_until = 0;
    end else begin
      fire = m_valid && ordy;
      if (fire) begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        if (m_b.lat > 0) stall_until = cyc + m_b.lat;
      end
      if (iv && rdy) begin m_b = ref_decode(w); m_valid = 1; end
      else if (f || fire) m_valid = 0;
    end
    cyc++;
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("md_busy", md_busy, cyc < stall_until);
    chk("issue_cnt", issue_cnt, m_cnt);
    if (m_valid) begin
      chk("ALUCtrl", ALUCtrl, m_b.alu);
      chk("ctrl", {Branch, MemtoReg, MemWrite, ALUSrc, ALUPCSrc, RegWrite}, m_b.ctrl);
      chk("illegal", illegal, m_b.ill);
      chk("regs", {rd, rs1, rs2, funct3}, {m_b.rd, m_b.rs1, m_b.rs2, m_b.f3});
    end
    if (!r) begin
      chk("rst_alu", ALUCtrl, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_ctrl", {Branch, MemtoReg, MemWrite, ALUSrc, ALUPCSrc, RegWrite}, 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = 0; flush = 0; out_ready = 0;
    step(); step();
    rst_n = 1;
  endtask

  initial begin
    int k;
    logic [31:0] stream[4];
    stream = '{I_ADD, I_SUB, I_LW, I_BEQ};

    // reset and a single add
    do_reset();
    out_ready = 1; in_valid = 1; instr = I_ADD;
    step();
    chk("add_valid", out_valid, 1);
    chk("add_alu", ALUCtrl, A_ADD);
    chk("add_regwrite", RegWrite, 1);
    chk("add_alusrc", ALUSrc, 0);
    chk("add_fields", {rd, rs1, rs2}, {5'd1, 5'd2, 5'd3});
    chk("add_illegal", illegal, 0);
    in_valid = 0;
    step();
    chk("add_issued", issue_cnt, 1);

    // backpressure: four-instruction stream, out_ready low for three cycles
    do_reset();
    in_valid = 1; instr = stream[0];
    step();
    instr = stream[1];
    repeat (3) step();
    chk("held_alu", ALUCtrl, A_ADD);
    out_ready = 1;
    for (int i = 1; i < 4; i++) begin instr = stream[i]; step(); end
    in_valid = 0;
    step();
    chk("stream_issued", issue_cnt, 4);

    // MUL then DIV stall: edges from issue to the next accept
    do_reset();
    out_ready = 1; in_valid = 1; instr = I_MUL;
    step();
    in_valid = 0;
    step();
    in_valid = 1; instr = I_ADDI; k = 0;
    do begin step(); k++; end while (!last_rdy && k < 40);
    chk("mul_accept_edges", k, MLAT);
    instr = I_DIV;
    step();
    in_valid = 0;
    step();
    in_valid = 1; instr = I_ADDI; k = 0;
    do begin step(); k++; end while (!last_rdy && k < 40);
    chk("div_accept_edges", k, DLAT);
    in_valid = 0;
    step();

    // illegal encodings
    in_valid = 1; instr = I_BAD;
    step();
    chk("bad_op_illegal", {out_valid, illegal, ALUCtrl}, {1'b1, 1'b1, 5'd0});
    instr = I_BADR;
    step();
    chk("bad_r_illegal", {out_valid, illegal, ALUCtrl}, {1'b1, 1'b1, 5'd0});
    chk("bad_r_ctrl", {Branch, MemtoReg, MemWrite, ALUSrc, ALUPCSrc, RegWrite}, 0);
    in_valid = 0;
    step();

    // flush with a held bundle and a waiting instruction
    out_ready = 0; in_valid = 1; instr = I_ADD;
    step();
    instr = I_SUB; flush = 1;
    step();
    chk("flush_valid", out_valid, 0);
    chk("flush_blocks", last_rdy, 0);
    flush = 0; in_valid = 0; out_ready = 1;
    step();

    // flush during a DIV stall keeps the stall
    in_valid = 1; instr = I_DIV;
    step();
    in_valid = 0;
    step();
    flush = 1;
    step();
    flush = 0;
    chk("flush_keeps_busy", md_busy, 1);
    repeat (16) step();

    // issue counter wrap at CNT_W=4
    do_reset();
    out_ready = 1; in_valid = 1; instr = I_ADDI;
    repeat (17) step();
    in_valid = 0;
    step();
    chk("cnt_wrap", issue_cnt, 1);

    // reset in the middle of a DIV stall
    do_reset();
    out_ready = 1; in_valid = 1; instr = I_DIV;
    step();
    in_valid = 0;
    repeat (3) step();
    rst_n = 0;
    step();
    chk("rel_busy", md_busy, 0);
    rst_n = 1; in_valid = 1; instr = I_ADD;
    step();
    chk("rel_ready", last_rdy, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      instr     = rand_instr();
      step();
    end
    rst_n = 1; in_valid = 0; flush = 0; out_ready = 1;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
